mux_1: RTL and testbench



---
 rtl/mux_1.sv | 47 ++++
 tb/tb_mux_1.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_1.sv
// Two-input word multiplexer: o = sel ? b : a.
// REGISTERED=1 adds a one-cycle output register with synchronous active-high reset.
module mux_1 #(
  parameter int WIDTH      = 4,
  parameter bit REGISTERED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] o
);

  logic [WIDTH-1:0] o_d;

  // An unknown select propagates as all-X instead of quietly favouring one input.
  always_comb begin
    case (sel)
      1'b0:    o_d = a;
      1'b1:    o_d = b;
      default: o_d = {WIDTH{1'bx}};
    endcase
  end

  generate
    if (REGISTERED) begin : g_reg
      logic [WIDTH-1:0] o_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          o_q <= '0;
        end else begin
          o_q <= o_d;
        end
      end

      assign o = o_q;
    end else begin : g_comb
      // clk and rst are legal but unused in the combinational build.
      logic unused_ctl;
      assign unused_ctl = clk ^ rst;
      assign o = o_d;
    end
  endgenerate

endmodule

// File: tb/tb_mux_1.sv
// Self-checking bench for mux_1: combinational and registered builds side by side,
// expected values queued at stimulus time and popped when the output is sampled.
module tb_mux_1;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       sel;
  logic [3:0] o_comb;
  logic [3:0] o_reg;

  int total;
  int bad;

  logic [3:0] comb_q[$];
  logic [3:0] reg_q[$];
  logic [3:0] exp;

  mux_1 #(.WIDTH(4), .REGISTERED(1'b0)) u_comb (
    .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel), .o(o_comb)
  );

  mux_1 #(.WIDTH(4), .REGISTERED(1'b1)) u_reg (
    .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel), .o(o_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; a = 4'hF; b = 4'hE; sel = 1'b1;
    for (int i = 0; i < 2; i++) begin
      reg_q.push_back(4'h0);
      @(posedge clk); #1;
      exp = reg_q.pop_front();
      total++;
      if (o_reg !== exp) begin
        bad++;
        $display("FAIL reset_edge%0d: got %h expected %h", i, o_reg, exp);
      end
    end
  endtask

  task automatic test_static_cases();
    logic [8:0] vec [3];
    vec[0] = {1'b0, 4'h0, 4'h0};
    vec[1] = {1'b0, 4'h0, 4'h1};
    vec[2] = {1'b1, 4'h1, 4'h0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      {sel, b, a} = vec[i];
      comb_q.push_back(vec[i][8] ? vec[i][7:4] : vec[i][3:0]);
      #1;
      exp = comb_q.pop_front();
      total++;
      if (o_comb !== exp) begin
        bad++;
        $display("FAIL static_case%0d: got %h expected %h", i, o_comb, exp);
      end
    end
  endtask

  task automatic test_toggle();
    logic [4:0] step [5];
    logic [3:0] want [5];
    // {sel, b}: a stays 4'hA throughout
    step[0] = {1'b0, 4'h5}; want[0] = 4'hA;
    step[1] = {1'b1, 4'h5}; want[1] = 4'h5;
    step[2] = {1'b0, 4'h5}; want[2] = 4'hA;
    step[3] = {1'b0, 4'h3}; want[3] = 4'hA;
    step[4] = {1'b0, 4'hC}; want[4] = 4'hA;
    a = 4'hA;
    for (int i = 0; i < 5; i++) begin
      {sel, b} = step[i];
      comb_q.push_back(want[i]);
      #1;
      exp = comb_q.pop_front();
      total++;
      if (o_comb !== exp) begin
        bad++;
        $display("FAIL toggle_step%0d: got %h expected %h", i, o_comb, exp);
      end
    end
    sel = 1'b1; b = 4'h5; a = 4'h0;
    comb_q.push_back(4'h5);
    #1;
    exp = comb_q.pop_front();
    total++;
    if (o_comb !== exp) begin
      bad++;
      $display("FAIL toggle_unselected_a: got %h expected %h", o_comb, exp);
    end
  endtask

  task automatic test_exhaustive();
    int errs;
    logic [8:0] v;
    errs = 0;
    for (int i = 0; i < 512; i++) begin
      v = i[8:0];
      a = v[3:0]; b = v[7:4]; sel = v[8];
      comb_q.push_back(v[8] ? v[7:4] : v[3:0]);
      #1;
      exp = comb_q.pop_front();
      total++;
      if (o_comb !== exp) begin
        bad++;
        errs++;
        if (errs <= 8)
          $display("FAIL exhaustive a=%h b=%h sel=%b: got %h expected %h",
                   a, b, sel, o_comb, exp);
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    rst = 1'b0; a = 4'h3; b = 4'hC; sel = 1'b1;
    reg_q.push_back(4'hC);
    #1;
    total++;
    if (o_reg !== 4'h0) begin
      bad++;
      $display("FAIL reg_latency_before_edge: got %h expected %h", o_reg, 4'h0);
    end
    @(posedge clk); #1;
    exp = reg_q.pop_front();
    total++;
    if (o_reg !== exp) begin
      bad++;
      $display("FAIL reg_first_load: got %h expected %h", o_reg, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ra, rb;
    logic       rs;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      a = ra; b = rb; sel = rs;
      reg_q.push_back(rs ? rb : ra);
      @(posedge clk); #1;
      exp = reg_q.pop_front();
      total++;
      if (o_reg !== exp) begin
        bad++;
        $display("FAIL b2b_cycle%0d: got %h expected %h", i, o_reg, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] held;
    @(negedge clk);
    rst = 1'b0; a = 4'h9; b = 4'h6; sel = 1'b0;
    reg_q.push_back(4'h9);
    @(posedge clk); #1;
    exp = reg_q.pop_front();
    held = exp;
    total++;
    if (o_reg !== exp) begin
      bad++;
      $display("FAIL midrst_preload: got %h expected %h", o_reg, exp);
    end
    // rst rises between edges: output must hold until the next edge
    rst = 1'b1;
    #2;
    total++;
    if (o_reg !== held) begin
      bad++;
      $display("FAIL midrst_between_edges: got %h expected %h", o_reg, held);
    end
    @(negedge clk);
    sel = 1'b1;
    reg_q.push_back(4'h0);
    @(posedge clk); #1;
    exp = reg_q.pop_front();
    total++;
    if (o_reg !== exp) begin
      bad++;
      $display("FAIL midrst_reset_wins: got %h expected %h", o_reg, exp);
    end
    @(negedge clk);
    rst = 1'b0; a = 4'h2; b = 4'hD; sel = 1'b1;
    reg_q.push_back(4'hD);
    @(posedge clk); #1;
    exp = reg_q.pop_front();
    total++;
    if (o_reg !== exp) begin
      bad++;
      $display("FAIL midrst_release_no_dead_cycle: got %h expected %h", o_reg, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; a = 4'h0; b = 4'h0; sel = 1'b0;
    test_reset();
    test_static_cases();
    test_toggle();
    test_exhaustive();
    test_registered();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
